fp_add_scheduler: RTL and testbench

// - Shares one combinational floating-point adder between NUM_REQ requesters.
// - Round-robin arbitration; registered operands and result; one operation in flight.
// - Sits between the vector/accumulator clients and the adder instance. Drives the adder through add_x/add_y and samples add_result.

---
 rtl/fp_arith_pkg.sv | 20 ++
 rtl/fp_add_scheduler_rr_arbiter.sv | 38 +++
 rtl/fp_add_scheduler.sv | 158 +++++++++++++++
 tb/tb_fp_add_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arith_pkg.sv
// Shared definitions for the FP32 adder scheduler: format widths, the
// scheduler state encoding and a signed-zero detector.
package fp_arith_pkg;

  localparam int FP32_W    = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } sched_state_t;

  // True for +0.0 and -0.0; the sign bit is ignored.
  function automatic logic fp_is_zero(input logic [FP32_W-1:0] v);
    return (v[FP_EXP_W+FP_FRAC_W-1:0] == {(FP_EXP_W+FP_FRAC_W){1'b0}});
  endfunction

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first asserted request
// found searching upward from ptr, wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_any
);

  int   best_s;
  int   best_dist_s;
  int   dist_s;
  logic take_s;

  // Choose the requester with the smallest upward distance from ptr.
  always_comb begin
    best_s      = 0;
    best_dist_s = N;
    dist_s      = 0;
    take_s      = 1'b0;
    for (int i = 0; i < N; i++) begin
      dist_s      = (i + N - int'(ptr)) % N;
      take_s      = req[i] && (dist_s < best_dist_s);
      best_dist_s = take_s ? dist_s : best_dist_s;
      best_s      = take_s ? i : best_s;
    end
    gnt_any = (best_dist_s < N);
    gnt_idx = ID_W'(best_s);
    for (int i = 0; i < N; i++) begin
      gnt_onehot[i] = gnt_any && (best_s == i);
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one external combinational FP32 adder between NUM_REQ requesters.
// Round-robin grant in IDLE, operands held in EXEC for ADD_LAT cycles,
// result held in RESP until the consumer takes it. One operation in flight.
// Optional feature: FPADD_SCHED_ZERO_BYPASS_EN answers operations with a
// +/-0 operand directly from the other operand without using the adder.
module fp_add_scheduler
  import fp_arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FP32_W-1:0] req_x,
  input  logic [NUM_REQ*FP32_W-1:0] req_y,
  output logic [FP32_W-1:0]         add_x,
  output logic [FP32_W-1:0]         add_y,
  input  logic [FP32_W-1:0]         add_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FP32_W-1:0]         rsp_result,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  sched_state_t       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FP32_W-1:0]  add_x_q, add_x_d;
  logic [FP32_W-1:0]  add_y_q, add_y_d;
  logic [FP32_W-1:0]  rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] gnt_onehot_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               gnt_any_s;
  logic [FP32_W-1:0]  gnt_x_s;
  logic [FP32_W-1:0]  gnt_y_s;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_any    (gnt_any_s)
  );

  // Mux the granted requester's operands out of the packed input buses.
  always_comb begin
    gnt_x_s = {FP32_W{1'b0}};
    gnt_y_s = {FP32_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot_s[i]) begin
        gnt_x_s = req_x[FP32_W*i +: FP32_W];
        gnt_y_s = req_y[FP32_W*i +: FP32_W];
      end else begin
        gnt_x_s = gnt_x_s;
        gnt_y_s = gnt_y_s;
      end
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    add_x_d      = add_x_q;
    add_y_d      = add_y_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any_s) begin
          rsp_id_d = gnt_idx_s;
`ifdef FPADD_SCHED_ZERO_BYPASS_EN
          if (fp_is_zero(gnt_x_s) || fp_is_zero(gnt_y_s)) begin
            // x+0 or 0+y needs no adder; both zero returns operand B.
            rsp_result_d = fp_is_zero(gnt_x_s) ? gnt_y_s : gnt_x_s;
            state_d      = S_RESP;
          end else begin
            add_x_d = gnt_x_s;
            add_y_d = gnt_y_s;
            cnt_d   = CNT_W'(ADD_LAT - 1);
            state_d = S_EXEC;
          end
`else
          add_x_d = gnt_x_s;
          add_y_d = gnt_y_s;
          cnt_d   = CNT_W'(ADD_LAT - 1);
          state_d = S_EXEC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          rsp_result_d = add_result;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          // Next search starts just past the requester that was served.
          rr_ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                      : rsp_id_q + ID_W'(1);
          state_d  = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= {ID_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      add_x_q      <= {FP32_W{1'b0}};
      add_y_q      <= {FP32_W{1'b0}};
      rsp_result_q <= {FP32_W{1'b0}};
      rsp_id_q     <= {ID_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      add_x_q      <= add_x_d;
      add_y_q      <= add_y_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) ? gnt_onehot_s : {NUM_REQ{1'b0}};
  assign add_x      = add_x_q;
  assign add_y      = add_y_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler. A transaction-level model predicts
// grants, response timing and payloads; directed literals pin the model.
// A second instance with ADD_LAT=3 covers reset during EXEC.
module tb_fp_add_scheduler;

  localparam int LAT = 1;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_x, req_y;
  logic [31:0]  add_x, add_y, add_result, rsp_result;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;

  logic         rst2_n;
  logic [3:0]   rv2, rdy2;
  logic [127:0] x2, y2;
  logic [31:0]  ax2, ay2, ar2, res2;
  logic         vld2, rr2, busy2;
  logic [1:0]   id2;

  int cyc  = 0;
  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int          id;
    logic [31:0] sum;
    int          due;
  } txn_t;

  txn_t        mq[$];
  int          m_ptr;
  logic [31:0] m_ax, m_ay;
  int          glog_id[$];
  int          glog_cyc[$];

  // Golden FP32 adder through double precision (normals and zero only).
  function automatic real f32_to_real(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_f32(f32_to_real(a) + f32_to_real(b));
  endfunction

  assign add_result = f32_add(add_x, add_y);
  assign ar2        = f32_add(ax2, ay2);

  fp_add_scheduler #(.NUM_REQ(4), .ID_W(2), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .add_x(add_x), .add_y(add_y),
    .add_result(add_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy));

  fp_add_scheduler #(.NUM_REQ(4), .ID_W(2), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst2_n), .req_valid(rv2), .req_ready(rdy2),
    .req_x(x2), .req_y(y2), .add_x(ax2), .add_y(ay2),
    .add_result(ar2), .rsp_valid(vld2), .rsp_ready(rr2),
    .rsp_result(res2), .rsp_id(id2), .busy(busy2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model + compare process for the ADD_LAT=1 instance, every cycle.
  always @(negedge clk) begin : cmp
    int          g;
    logic [3:0]  exp_rr;
    logic        exp_busy, exp_rv, bp;
    logic [31:0] gx, gy;
    if (!rst_n) begin
      mq.delete();
      m_ptr = 0;
      m_ax  = 32'd0;
      m_ay  = 32'd0;
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_add_x", add_x, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    end else begin
      g = -1;
      exp_busy = (mq.size() > 0);
      exp_rv   = exp_busy && (cyc >= mq[0].due);
      if (!exp_busy) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr + k) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rr = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
      chk("req_ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      chk("add_x", add_x, m_ax);
      chk("add_y", add_y, m_ay);
      if (exp_rv) begin
        chk("rsp_result", rsp_result, mq[0].sum);
        chk("rsp_id", {30'd0, rsp_id}, mq[0].id);
      end
      if (g >= 0) begin
        gx = req_x[32*g +: 32];
        gy = req_y[32*g +: 32];
        bp = 1'b0;
`ifdef FPADD_SCHED_ZERO_BYPASS_EN
        bp = (gx[30:0] == 31'd0) || (gy[30:0] == 31'd0);
`endif
        glog_id.push_back(g);
        glog_cyc.push_back(cyc);
        if (bp) begin
          mq.push_back('{id: g, sum: (gx[30:0] == 31'd0) ? gy : gx, due: cyc + 1});
        end else begin
          mq.push_back('{id: g, sum: f32_add(gx, gy), due: cyc + LAT + 1});
          m_ax = gx;
          m_ay = gy;
        end
      end else if (exp_rv && rsp_ready) begin
        m_ptr = (mq[0].id + 1) % 4;
        void'(mq.pop_front());
      end
    end
  end

  task automatic wait_grants(input int n, input int budget);
    int k;
    k = 0;
    while (glog_id.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("grant_wait", {31'd0, glog_id.size() >= n}, 32'd1);
  endtask

  initial begin : stim
    int exp_ids[5];
    int k;
    logic seen;
    exp_ids = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req_valid = 4'd0; req_x = 128'd0; req_y = 128'd0; rsp_ready = 1'b1;
    rst2_n = 1'b0; rv2 = 4'd0; x2 = 128'd0; y2 = 128'd0; rr2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_rst_busy", {31'd0, busy}, 32'd0);
    chk("lit_rst_add_y", add_y, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; rst2_n = 1'b1;

    // Contention: all four requesting, consumer always ready.
    req_x = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_y = {32'h40000000, 32'h3E800000, 32'hBF800000, 32'h3F000000};
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'hF;
    wait_grants(5, 40);
    @(posedge clk); #1 req_valid = 4'd0;
    for (int i = 0; i < 5; i++)
      if (glog_id.size() > i) chk("cont_grant_id", glog_id[i], exp_ids[i]);
    for (int i = 1; i < 5; i++)
      if (glog_cyc.size() > i) chk("cont_grant_gap", glog_cyc[i] - glog_cyc[i-1], 3);
    repeat (4) @(negedge clk);

    // Single request: 1.0 + 2.0 = 3.0 from requester 0.
    @(posedge clk); #1 req_x[31:0] = 32'h3F800000; req_y[31:0] = 32'h40000000; req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready_T", {28'd0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 4'd0;
    @(negedge clk);
    chk("single_busy_T1", {31'd0, busy}, 32'd1);
    chk("single_novalid_T1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("single_valid_T2", {31'd0, rsp_valid}, 32'd1);
    chk("single_result", rsp_result, 32'h40400000);
    chk("single_id", {30'd0, rsp_id}, 32'd0);
    chk("single_busy_T2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("single_idle_T3", {31'd0, busy}, 32'd0);

    // Rotation: serve 2, then 0101 must grant 0 before 2.
    glog_id.delete(); glog_cyc.delete();
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_grants(1, 10);
    @(posedge clk); #1 req_valid = 4'b0101;
    wait_grants(3, 20);
    @(posedge clk); #1 req_valid = 4'd0;
    if (glog_id.size() > 2) begin
      chk("rot_first", glog_id[0], 2);
      chk("rot_next", glog_id[1], 0);
      chk("rot_after", glog_id[2], 2);
    end
    repeat (4) @(negedge clk);

    // Backpressure: pointer is at 3, so requester 3 computes 4.0 + 2.0 = 6.0.
    @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 4'hF;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
    chk("bp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result_held", rsp_result, 32'h40C00000);
      chk("bp_id_held", {30'd0, rsp_id}, 32'd3);
      chk("bp_no_ready", {28'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1; req_valid = 4'd0;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("bp_release_idle", {31'd0, busy}, 32'd0);

    // Zero operand: 0 + 3.0 from requester 0.
    @(posedge clk); #1 req_x[31:0] = 32'h00000000; req_y[31:0] = 32'h40400000; req_valid = 4'b0001;
    @(negedge clk);
    chk("zero_ready_T", {28'd0, req_ready}, 32'h1);
    @(posedge clk); #1 req_valid = 4'd0;
    @(negedge clk);
`ifdef FPADD_SCHED_ZERO_BYPASS_EN
    chk("byp_valid_T1", {31'd0, rsp_valid}, 32'd1);
    chk("byp_result", rsp_result, 32'h40400000);
    chk("byp_add_x_kept", add_x, 32'h40800000);
    chk("byp_add_y_kept", add_y, 32'h40000000);
    @(negedge clk);
`else
    chk("zero_novalid_T1", {31'd0, rsp_valid}, 32'd0);
    chk("zero_add_x", add_x, 32'h00000000);
    chk("zero_add_y", add_y, 32'h40400000);
    @(negedge clk);
    chk("zero_valid_T2", {31'd0, rsp_valid}, 32'd1);
    chk("zero_result", rsp_result, 32'h40400000);
`endif
    repeat (2) @(negedge clk);

    // Reset in the second EXEC cycle of the ADD_LAT=3 instance.
    @(posedge clk); #1 rv2 = 4'b0100; x2[95:64] = 32'h3F800000; y2[95:64] = 32'h3F800000;
    @(negedge clk);
    chk("r3_ready_T", {28'd0, rdy2}, 32'h4);
    @(posedge clk); #1 rv2 = 4'd0;
    @(negedge clk);
    chk("r3_busy_exec1", {31'd0, busy2}, 32'd1);
    @(posedge clk); #1 rst2_n = 1'b0;
    #1;
    chk("r3_rst_busy", {31'd0, busy2}, 32'd0);
    chk("r3_rst_valid", {31'd0, vld2}, 32'd0);
    chk("r3_rst_ready", {28'd0, rdy2}, 32'd0);
    chk("r3_rst_add_x", ax2, 32'd0);
    chk("r3_rst_add_y", ay2, 32'd0);
    chk("r3_rst_result", res2, 32'd0);
    chk("r3_rst_id", {30'd0, id2}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst2_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (vld2) seen = 1'b1;
    end
    chk("r3_no_response", {31'd0, seen}, 32'd0);
    @(posedge clk); #1 rv2 = 4'hF;
    @(negedge clk);
    chk("r3_ptr_zero", {28'd0, rdy2}, 32'h1);
    @(posedge clk); #1 rv2 = 4'd0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
